// File: rtl/bufg_gt_ctrl_pkg.sv
// Shared types and constants for the GT clock divide buffer sequencer.
// DIV code n selects divide-by-(n+1).
package bufg_gt_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    GATE,
    CLEAR,
    RELEASE,
    ENABLE,
    DONE
  } state_t;

  localparam logic [2:0] DIV1 = 3'd0;
  localparam logic [2:0] DIV2 = 3'd1;
  localparam logic [2:0] DIV3 = 3'd2;
  localparam logic [2:0] DIV4 = 3'd3;
  localparam logic [2:0] DIV5 = 3'd4;
  localparam logic [2:0] DIV6 = 3'd5;
  localparam logic [2:0] DIV7 = 3'd6;
  localparam logic [2:0] DIV8 = 3'd7;

  localparam int GATE_CYC_DEF   = 4;
  localparam int CLR_CYC_DEF    = 2;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int EN_CYC_DEF     = 16;
  localparam int CNT_W_DEF      = 5;

endpackage

// File: rtl/bufg_gt_ctrl_if.sv
// Request handshake plus buffer control pins between requester, sequencer and GT divide buffer.
// master = requester side, slave = sequencer side.
interface bufg_gt_ctrl_if;

  logic       req;
  logic [2:0] div_new;
  logic       ack;
  logic       busy;
  logic       ready;
  logic       ce;
  logic       cemask;
  logic       clr;
  logic       clrmask;
  logic [2:0] div;

  modport master (
    output req, div_new,
    input  ack, busy, ready, ce, cemask, clr, clrmask, div
  );

  modport slave (
    input  req, div_new,
    output ack, busy, ready, ce, cemask, clr, clrmask, div
  );

endinterface

// File: rtl/bufg_gt_ctrl.sv
// Glitch-free power-up and divide-ratio change sequencer for a GT clock divide buffer.
// Optional macro BUFG_GT_CTRL_SAME_DIV_SKIP_EN: requests for the current DIV acknowledge without a sequence.
module bufg_gt_ctrl
  import bufg_gt_ctrl_pkg::*;
#(
  parameter logic [2:0] DIV_INIT   = DIV1,
  parameter int         GATE_CYC   = GATE_CYC_DEF,
  parameter int         CLR_CYC    = CLR_CYC_DEF,
  parameter int         SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int         EN_CYC     = EN_CYC_DEF,
  parameter int         CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bufg_gt_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD    = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD     = CNT_W'(EN_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_req_q, from_req_d;
  logic             capture;
  logic [2:0]       div_nxt_q;

  logic             ce_q, ce_d;
  logic             clr_q, clr_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [2:0]       div_q, div_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    from_req_d = from_req_q;
    capture    = 1'b0;

    case (state_q)
      RST_HOLD: if (cnt_q == '0) begin
        state_d = RELEASE;
        cnt_d   = SETTLE_LD;
      end
      IDLE: if (bus.req) begin
        capture    = 1'b1;
        from_req_d = 1'b1;
`ifdef BUFG_GT_CTRL_SAME_DIV_SKIP_EN
        if (bus.div_new == div_q) begin
          state_d = DONE;
        end else begin
          state_d = GATE;
          cnt_d   = GATE_LD;
        end
`else
        state_d = GATE;
        cnt_d   = GATE_LD;
`endif
      end
      GATE: if (cnt_q == '0) begin
        state_d = CLEAR;
        cnt_d   = CLR_LD;
      end
      CLEAR: if (cnt_q == '0) begin
        state_d = RELEASE;
        cnt_d   = SETTLE_LD;
      end
      RELEASE: if (cnt_q == '0) begin
        state_d = ENABLE;
        cnt_d   = EN_LD;
      end
      ENABLE: if (cnt_q == '0) begin
        state_d    = from_req_q ? DONE : IDLE;
        from_req_d = 1'b0;
      end
      DONE: if (!bus.req) begin
        state_d = IDLE;
      end
      default: state_d = RST_HOLD;
    endcase

    // Outputs are decoded from the next state so each flop matches the state it enters.
    ce_d    = 1'b0;
    clr_d   = 1'b0;
    ack_d   = 1'b0;
    busy_d  = 1'b1;
    ready_d = 1'b0;
    div_d   = div_q;

    case (state_d)
      RST_HOLD: clr_d = 1'b1;
      IDLE: begin
        ce_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      CLEAR: clr_d = 1'b1;
      ENABLE: ce_d = 1'b1;
      DONE: begin
        ce_d    = 1'b1;
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: ;
    endcase

    // DIV only moves on CLEAR entry, when CLR is asserting in the same cycle.
    if (state_d == CLEAR && state_q != CLEAR) begin
      div_d = div_nxt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_HOLD;
      cnt_q      <= CLR_LD;
      from_req_q <= 1'b0;
      ce_q       <= 1'b0;
      clr_q      <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      div_q      <= DIV_INIT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_req_q <= from_req_d;
      ce_q       <= ce_d;
      clr_q      <= clr_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      div_q      <= div_d;
    end
  end

  // Captured ratio is only consumed after a reset-free trip through GATE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      div_nxt_q <= bus.div_new;
    end
  end

  assign bus.ce      = ce_q;
  assign bus.cemask  = 1'b0;
  assign bus.clr     = clr_q;
  assign bus.clrmask = 1'b0;
  assign bus.div     = div_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_bufg_gt_ctrl.sv
// Randomized bench for bufg_gt_ctrl against a timeline model of the change sequence,
// plus a simple GT divide buffer model for output period measurement.
module tb_bufg_gt_ctrl;

  localparam int G = 4;
  localparam int C = 2;
  localparam int S = 4;
  localparam int E = 16;
  localparam int T = G + C + S + E;

  localparam int M_RST  = 0;
  localparam int M_SEQ  = 1;
  localparam int M_IDLE = 2;
  localparam int M_ACK  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bufg_gt_ctrl_if ifc ();

  bufg_gt_ctrl #(
    .DIV_INIT  (3'b000),
    .GATE_CYC  (G),
    .CLR_CYC   (C),
    .SETTLE_CYC(S),
    .EN_CYC    (E),
    .CNT_W     (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;

  // Model: a sequence is a position p along gate/clear/release/enable; power-up starts at p=G.
  int         m_mode = M_RST;
  int         m_p    = 0;
  bit         m_from_req = 1'b0;
  logic [2:0] m_div  = 3'b000;
  logic [2:0] m_pend = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    case (m_mode)
      M_SEQ: begin
        m_p++;
        if (m_from_req && m_p == G) m_div = m_pend;
        if (m_p == T) m_mode = m_from_req ? M_ACK : M_IDLE;
      end
      M_IDLE: if (ifc.req) begin
        m_pend     = ifc.div_new;
        m_from_req = 1'b1;
`ifdef BUFG_GT_CTRL_SAME_DIV_SKIP_EN
        if (ifc.div_new == m_div) begin
          m_mode = M_ACK;
        end else begin
          m_mode = M_SEQ;
          m_p    = 0;
        end
`else
        m_mode = M_SEQ;
        m_p    = 0;
`endif
      end
      M_ACK: if (!ifc.req) m_mode = M_IDLE;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic e_ce, e_clr, e_ack, e_busy, e_ready;
    e_ce = 1'b0; e_clr = 1'b0; e_ack = 1'b0; e_busy = 1'b1; e_ready = 1'b0;
    case (m_mode)
      M_RST: e_clr = 1'b1;
      M_SEQ: begin
        e_ce  = (m_p >= G + C + S);
        e_clr = (m_p >= G) && (m_p < G + C);
      end
      M_IDLE: begin e_ce = 1'b1; e_busy = 1'b0; e_ready = 1'b1; end
      default: begin e_ce = 1'b1; e_ack = 1'b1; e_busy = 1'b0; e_ready = 1'b1; end
    endcase
    chk("ce",      32'(ifc.ce),      32'(e_ce));
    chk("clr",     32'(ifc.clr),     32'(e_clr));
    chk("div",     32'(ifc.div),     32'(m_div));
    chk("ack",     32'(ifc.ack),     32'(e_ack));
    chk("busy",    32'(ifc.busy),    32'(e_busy));
    chk("ready",   32'(ifc.ready),   32'(e_ready));
    chk("cemask",  32'(ifc.cemask),  32'd0);
    chk("clrmask", 32'(ifc.clrmask), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare_all();
  endtask

  task automatic release_reset();
    rst        = 1'b0;
    m_mode     = M_SEQ;
    m_p        = G;
    m_from_req = 1'b0;
    m_div      = 3'b000;
  endtask

  task automatic req_and_wait(input logic [2:0] d, output int lat);
    ifc.div_new = d;
    ifc.req     = 1'b1;
    lat         = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ifc.ack) begin
        lat = i;
        break;
      end
    end
  endtask

  // Behavioural divide buffer: 2-flop CE/CLR sync, one-cycle pulse every DIV+1 cycles.
  logic [1:0] ce_s  = 2'b00;
  logic [1:0] clr_s = 2'b11;
  logic [2:0] bcnt  = 3'd0;
  logic       bo    = 1'b0;

  always @(posedge clk) begin
    ce_s  <= {ce_s[0], ifc.ce};
    clr_s <= {clr_s[0], ifc.clr};
    if (clr_s[1]) begin
      bcnt <= 3'd0;
      bo   <= 1'b0;
    end else if (ce_s[1]) begin
      if (bcnt >= ifc.div) begin
        bcnt <= 3'd0;
        bo   <= 1'b1;
      end else begin
        bcnt <= bcnt + 3'd1;
        bo   <= 1'b0;
      end
    end
  end

  task automatic measure_period(output int per);
    int  first;
    logic prev;
    per   = 0;
    first = -1;
    prev  = bo;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bo && !prev) begin
        if (first < 0) first = i;
        else begin
          per = i - first;
          break;
        end
      end
      prev = bo;
    end
  endtask

  // Safety monitor: CE may not rise under CLR, DIV may not move without CLR.
  logic       ce_m  = 1'b0;
  logic [2:0] div_m = 3'b000;
  always @(posedge clk) begin
    ce_m  <= ifc.ce;
    div_m <= ifc.div;
    if (!rst) begin
      if (ifc.ce && !ce_m && ifc.clr) viol <= viol + 1;
      else if (ifc.div != div_m && !ifc.clr) viol <= viol + 1;
    end
  end

  initial begin
    int lat, per, clr_fall, ce_rise, rdy_at, exp_same;
    ifc.req     = 1'b0;
    ifc.div_new = 3'b000;

    for (int i = 0; i < 10; i++) tick();

    #1;
    release_reset();
    clr_fall = -1; ce_rise = -1; rdy_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (clr_fall < 0 && !ifc.clr) clr_fall = i;
      if (ce_rise < 0 && ifc.ce) ce_rise = i;
      if (rdy_at < 0 && ifc.ready) rdy_at = i;
    end
    chk("pwr_clr_fall", 32'(clr_fall), 32'd2);
    chk("pwr_ce_rise",  32'(ce_rise),  32'd6);
    chk("pwr_ready",    32'(rdy_at),   32'd22);

    req_and_wait(3'b011, lat);
    chk("lat_011", 32'(lat), 32'd27);
    ifc.div_new = 3'b101;
    for (int i = 0; i < 10; i++) tick();
    chk("no_retrig_div", 32'(ifc.div), 32'h3);
    ifc.req = 1'b0;
    tick();
    chk("ack_drop", 32'(ifc.ack), 32'd0);
    req_and_wait(3'b101, lat);
    chk("lat_101", 32'(lat), 32'd27);
    ifc.req = 1'b0;
    tick();

`ifdef BUFG_GT_CTRL_SAME_DIV_SKIP_EN
    exp_same = 1;
`else
    exp_same = 27;
`endif
    req_and_wait(3'b101, lat);
    chk("lat_same", 32'(lat), 32'(exp_same));
    ifc.req = 1'b0;
    tick();

    req_and_wait(3'b111, lat);
    measure_period(per);
    chk("period_div8", 32'(per), 32'd8);
    ifc.req = 1'b0;
    tick();
    req_and_wait(3'b010, lat);
    measure_period(per);
    chk("period_div3", 32'(per), 32'd3);
    ifc.req = 1'b0;
    tick();

    for (int r = 0; r < 12; r++) begin
      ifc.req = 1'b0;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick();
      ifc.div_new = 3'($urandom_range(0, 7));
      ifc.req     = 1'b1;
      for (int i = 0; i < 60 && !ifc.ack; i++) begin
        tick();
        if ($urandom_range(0, 2) == 0) ifc.div_new = 3'($urandom_range(0, 7));
      end
      chk("rand_ack", 32'(ifc.ack), 32'd1);
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        ifc.div_new = 3'($urandom_range(0, 7));
        tick();
      end
      ifc.req = 1'b0;
      tick();
    end

    // Reset in the middle of CLEAR with a pending ratio of 111.
    ifc.div_new = 3'b111;
    ifc.req     = 1'b1;
    for (int i = 0; i < 60 && !(m_mode == M_SEQ && m_p == G); i++) tick();
    chk("reached_clear", 32'(ifc.clr), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    m_mode = M_RST;
    m_div  = 3'b000;
    compare_all();
    ifc.div_new = 3'b110;
    for (int i = 0; i < 5; i++) tick();
    release_reset();
    for (int i = 0; i < 80 && !ifc.ack; i++) tick();
    chk("pend_accept_ack", 32'(ifc.ack), 32'd1);
    chk("pend_accept_div", 32'(ifc.div), 32'h6);
    ifc.req = 1'b0;
    tick();
    tick();

    chk("safety_viol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
